tt_sweep_capture: RTL and testbench
===================================

Name: tt_sweep_capture

Overview:
- Sequential harness stage wrapped around one combinational single-output benchmark restriction, such as a 6-input PLA restriction after mockturtle optimisation.
- Upstream role: drives the exhaustive input vector sweep into the function's inputs.
- Downstream role: captures the function's output, one bit per vector, into a truth-table word.
- Reports the truth table, its onset weight and a match flag against an expected table, so on-chip checks need no external vector memory.

Parameters:
- N_IN, 6, number of function inputs; the sweep covers 2**N_IN vectors.
- SETTLE, 0, extra cycles between presenting a vector and sampling resp_i. Use 0 for a purely combinational function, k for a k-stage registered one.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a sweep, honoured only in IDLE
- exp_tt_i  in  2**N_IN  expected truth table, sampled on the accepted start
- vec_o  out  N_IN  current input vector to the function (bit j drives xj)
- resp_i  in  1  function output (y0)
- busy  out  1  high from the accepted start until the result is accepted
- tt_o  out  2**N_IN  captured truth table; bit i = response to vector i
- weight_o  out  N_IN+1  number of ones in tt_o
- match_o  out  1  tt_o == latched expected table
- tt_valid  out  1  result valid
- tt_ready  in  1  result consumer ready

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - vec_o, tt_o, weight_o, match_o, tt_valid, busy all 0.
  - Internal wait counter and latched expected table cleared.
  - Reset mid-sweep aborts the sweep immediately; no partial result is ever presented.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 → latch exp_tt_i; clear tt_o and weight_o; set vec_o=0; busy=1; go to APPLY.
  - start=0 → remain in IDLE.
- APPLY:
  - Wait counter counts from 0 up to SETTLE.
  - When count==SETTLE, go to SAMPLE.
  - With SETTLE=0, APPLY lasts exactly 1 cycle.
- SAMPLE (1 cycle):
  - tt_o[vec_o] <= resp_i; weight_o += resp_i.
  - If vec_o == 2**N_IN-1: go to DONE and compute match_o.
  - Otherwise: vec_o += 1 (no wrap within a sweep), reset the wait counter, return to APPLY.
- Timing:
  - Each vector occupies SETTLE+2 cycles.
  - tt_valid rises exactly 2**N_IN*(SETTLE+2)+1 cycles after the accepted start edge.
- DONE:
  - tt_valid=1; tt_o, weight_o and match_o held stable while tt_valid=1 and tt_ready=0.
  - tt_valid&&tt_ready → next cycle: tt_valid=0, busy=0, state IDLE.
  - tt_o, weight_o and match_o keep their last values in IDLE; vec_o returns to 0.
- start while busy: ignored, with no queueing.
- start in the same cycle as the acceptance in DONE: ignored; a new start is honoured from IDLE on.
- weight_o width N_IN+1 covers the all-ones case (64 for N_IN=6) without overflow.
- resp_i is sampled only in SAMPLE and is ignored elsewhere (X-tolerant outside SAMPLE).
- exp_tt_i changes after the accepted start have no effect.

Decomposition:
- Shared package tt_sweep_pkg:
  - state enum (IDLE/APPLY/SAMPLE/DONE);
  - function tt_width(n) = 2**n;
  - default-parameter localparams.
- One natural sub-module: tt_vec_counter, holding the vector index plus settle counter with wrap/last flags.
- The FSM, capture register, weight accumulator and comparator stay in the top module.

Test Plan:
- resp_i tied 0, exp_tt_i=0, start → tt_o=0, weight_o=0, match_o=1, tt_valid after 129 cycles (N_IN=6, SETTLE=0).
- resp_i=vec_o[1], exp_tt_i=64'hCCCC_CCCC_CCCC_CCCC → tt_o=64'hCCCC_CCCC_CCCC_CCCC, weight_o=32, match_o=1.
- resp_i=&vec_o, exp_tt_i=0 → tt_o=64'h8000_0000_0000_0000, weight_o=1, match_o=0.
- SETTLE=2 with a 2-stage registered model of resp_i=vec_o[0]:
  - tt_o=64'hAAAA_AAAA_AAAA_AAAA, weight_o=32;
  - tt_valid after 257 cycles;
  - a second start mid-sweep is ignored.
- tt_ready held low 10 cycles in DONE → tt_o, weight_o and match_o stable, tt_valid held; after the handshake busy=0 and the next start restarts from vec_o=0.
- rst_n asserted at vector 20 mid-sweep → all outputs 0 asynchronously; a following full sweep yields the correct table.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep/capture harness.
// The state encoding and table-width helper are common to the top and the vector counter.
package tt_sweep_pkg;

    localparam int unsigned N_IN_DEF   = 6;
    localparam int unsigned SETTLE_DEF = 0;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_e;

    function automatic int unsigned tt_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// Vector index and settle-wait counter for the exhaustive input sweep.
// Reports when the current vector has settled and when it is the last vector.
module tt_vec_counter
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            count_i,
    input  logic            advance_i,
    output logic [N_IN-1:0] vec_o,
    output logic            settle_done_o,
    output logic            last_o
);

    localparam int unsigned WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [WW-1:0]   wait_q, wait_d;
    logic [N_IN-1:0] vec_q, vec_d;

    assign settle_done_o = (wait_q == WW'(SETTLE));
    assign last_o        = (vec_q == '1);
    assign vec_o         = vec_q;

    always_comb begin
        wait_d = wait_q;
        vec_d  = vec_q;
        if (clear_i) begin
            wait_d = '0;
            vec_d  = '0;
        end else if (advance_i) begin
            wait_d = '0;
            // Saturate at the last vector so a sweep never wraps.
            vec_d  = last_o ? vec_q : vec_q + 1'b1;
        end else if (count_i && !settle_done_o) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            vec_q  <= '0;
        end else begin
            wait_q <= wait_d;
            vec_q  <= vec_d;
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2**N_IN input vectors into a combinational/registered function and
// captures its response as a truth table with onset weight and expected-table match.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [tt_width(N_IN)-1:0] exp_tt_i,
    output logic [N_IN-1:0]           vec_o,
    input  logic                      resp_i,
    output logic                      busy,
    output logic [tt_width(N_IN)-1:0] tt_o,
    output logic [N_IN:0]             weight_o,
    output logic                      match_o,
    output logic                      tt_valid,
    input  logic                      tt_ready
);

    localparam int unsigned TW = tt_width(N_IN);

    state_e          state_q, state_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [N_IN:0]   weight_q, weight_d;
    logic            match_q, match_d;
    logic            valid_q, valid_d;

    logic            settle_done;
    logic            last_vec;
    logic            accept_start;
    logic            accept_result;
    logic            cnt_clear;
    logic            cnt_count;
    logic            cnt_advance;

    assign accept_start  = (state_q == IDLE) && start;
    assign accept_result = (state_q == DONE) && valid_q && tt_ready;
    assign cnt_clear     = accept_start || accept_result;
    assign cnt_count     = (state_q == APPLY);
    assign cnt_advance   = (state_q == SAMPLE) && !last_vec;

    tt_vec_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vec_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (cnt_clear),
        .count_i       (cnt_count),
        .advance_i     (cnt_advance),
        .vec_o         (vec_o),
        .settle_done_o (settle_done),
        .last_o        (last_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)         state_d = APPLY;
            APPLY:   if (settle_done)   state_d = SAMPLE;
            SAMPLE:  state_d = last_vec ? DONE : APPLY;
            DONE:    if (accept_result) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        exp_d    = exp_q;
        tt_d     = tt_q;
        weight_d = weight_q;
        match_d  = match_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d    = exp_tt_i;
                    tt_d     = '0;
                    weight_d = '0;
                    match_d  = 1'b0;
                end
            end
            SAMPLE: begin
                tt_d[vec_o] = resp_i;
                weight_d    = weight_q + {{N_IN{1'b0}}, resp_i};
            end
            DONE: begin
                // First DONE cycle compares the completed table and raises valid.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    match_d = (tt_q == exp_q);
                end else if (tt_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= '0;
            tt_q     <= '0;
            weight_q <= '0;
            match_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            weight_q <= weight_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
        end
    end

    assign tt_o     = tt_q;
    assign weight_o = weight_q;
    assign match_o  = match_q;
    assign tt_valid = valid_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a SETTLE=0 instance driven by selectable functions and
// a SETTLE=2 instance driven by a two-stage registered function of vec_o[0].
module tb_tt_sweep_capture;

    typedef struct {
        logic [63:0] tt;
        logic [6:0]  w;
        logic        m;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb2[$];

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0, rdy0 = 1'b0, resp0;
    logic [63:0] exp0 = '0, tt0;
    logic [5:0]  vec0;
    logic [6:0]  w0;
    logic        busy0, m0, v0;
    int          mode0 = 0;

    logic        start2 = 1'b0, rdy2 = 1'b0, resp2;
    logic [63:0] exp2 = '0, tt2;
    logic [5:0]  vec2;
    logic [6:0]  w2;
    logic        busy2, m2, v2;
    logic        r1 = 1'b0, r2 = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        resp0 = 1'b0;
        case (mode0)
            1: resp0 = vec0[1];
            2: resp0 = &vec0;
            3: resp0 = 1'b1;
            default: resp0 = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        r1 <= vec2[0];
        r2 <= r1;
    end
    assign resp2 = r2;

    tt_sweep_capture #(.N_IN(6), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_tt_i(exp0), .vec_o(vec0),
        .resp_i(resp0), .busy(busy0), .tt_o(tt0), .weight_o(w0), .match_o(m0),
        .tt_valid(v0), .tt_ready(rdy0)
    );

    tt_sweep_capture #(.N_IN(6), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .exp_tt_i(exp2), .vec_o(vec2),
        .resp_i(resp2), .busy(busy2), .tt_o(tt2), .weight_o(w2), .match_o(m2),
        .tt_valid(v2), .tt_ready(rdy2)
    );

    task automatic test_reset();
        #3;
        checks++;
        if ({vec0, tt0, w0, m0, v0, busy0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got vec=%h tt=%h w=%0d m=%b v=%b busy=%b expected all 0",
                     vec0, tt0, w0, m0, v0, busy0);
        end
        checks++;
        if ({vec2, tt2, w2, m2, v2, busy2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got vec=%h tt=%h w=%0d m=%b v=%b busy=%b expected all 0",
                     vec2, tt2, w2, m2, v2, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep on dut0 and compares the popped scoreboard entry with the result.
    task automatic sweep0(input int mode, input logic [63:0] exp_tt, input logic [63:0] tt_e,
                          input logic [6:0] w_e, input logic m_e, input string name);
        exp_t e;
        int   cyc;
        mode0 = mode;
        exp0  = exp_tt;
        sb0.push_back('{tt_e, w_e, m_e, 129});
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        exp0   = ~exp_tt;
        checks++;
        if (busy0 !== 1'b1 || vec0 !== 6'd0) begin
            errors++;
            $display("FAIL %s_start: got busy=%b vec=%0d expected busy=1 vec=0", name, busy0, vec0);
        end
        cyc = 0;
        while (v0 !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
            return;
        end
        e = sb0.pop_front();
        checks++;
        if (cyc !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, e.lat);
        end
        checks++;
        if (tt0 !== e.tt) begin
            errors++;
            $display("FAIL %s_tt: got %h expected %h", name, tt0, e.tt);
        end
        checks++;
        if (w0 !== e.w) begin
            errors++;
            $display("FAIL %s_weight: got %0d expected %0d", name, w0, e.w);
        end
        checks++;
        if (m0 !== e.m) begin
            errors++;
            $display("FAIL %s_match: got %b expected %b", name, m0, e.m);
        end
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
        checks++;
        if (v0 !== 1'b0 || busy0 !== 1'b0 || vec0 !== 6'd0 || tt0 !== e.tt) begin
            errors++;
            $display("FAIL %s_accept: got v=%b busy=%b vec=%0d tt=%h expected v=0 busy=0 vec=0 tt=%h",
                     name, v0, busy0, vec0, tt0, e.tt);
        end
    endtask

    task automatic test_functions();
        sweep0(0, 64'h0, 64'h0, 7'd0, 1'b1, "zero");
        sweep0(1, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC, 7'd32, 1'b1, "bit1");
        sweep0(2, 64'h0, 64'h8000_0000_0000_0000, 7'd1, 1'b0, "and6");
        sweep0(3, '1, '1, 7'd64, 1'b1, "ones");
    endtask

    task automatic test_settle2();
        exp_t e;
        int   cyc;
        exp2 = 64'hAAAA_AAAA_AAAA_AAAA;
        sb2.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 1'b1, 257});
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc = 0;
        while (v2 !== 1'b1 && cyc < 2000) begin
            start2 = (cyc == 50);
            exp2   = (cyc == 50) ? 64'h0 : exp2;
            @(posedge clk);
            #1;
            cyc++;
        end
        start2 = 1'b0;
        e = sb2.pop_front();
        checks++;
        if (cyc !== e.lat) begin
            errors++;
            $display("FAIL settle2_latency: got %0d expected %0d", cyc, e.lat);
        end
        checks++;
        if (tt2 !== e.tt || w2 !== e.w || m2 !== e.m) begin
            errors++;
            $display("FAIL settle2_result: got tt=%h w=%0d m=%b expected tt=%h w=%0d m=%b",
                     tt2, w2, m2, e.tt, e.w, e.m);
        end
        rdy2 = 1'b1;
        @(posedge clk);
        #1;
        rdy2 = 1'b0;
        checks++;
        if (v2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL settle2_accept: got v=%b busy=%b expected 0 0", v2, busy2);
        end
    endtask

    task automatic test_hold();
        exp_t        e;
        int          cyc;
        int          bad;
        logic [63:0] snap_tt;
        logic [6:0]  snap_w;
        logic        snap_m;
        mode0 = 2;
        exp0  = 64'h8000_0000_0000_0000;
        sb0.push_back('{64'h8000_0000_0000_0000, 7'd1, 1'b1, 129});
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 0;
        while (v0 !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb0.pop_front();
        checks++;
        if (tt0 !== e.tt || w0 !== e.w || m0 !== e.m || cyc !== e.lat) begin
            errors++;
            $display("FAIL hold_result: got tt=%h w=%0d m=%b lat=%0d expected tt=%h w=%0d m=%b lat=%0d",
                     tt0, w0, m0, cyc, e.tt, e.w, e.m, e.lat);
        end
        snap_tt = e.tt;
        snap_w  = e.w;
        snap_m  = e.m;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (v0 !== 1'b1 || busy0 !== 1'b1 || tt0 !== snap_tt || w0 !== snap_w || m0 !== snap_m)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        rdy0   = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0   = 1'b0;
        start0 = 1'b0;
        checks++;
        if (v0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: got v=%b busy=%b expected 0 0", v0, busy0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || tt0 !== snap_tt || w0 !== snap_w) begin
            errors++;
            $display("FAIL start_on_accept_ignored: got busy=%b tt=%h w=%0d expected busy=0 tt=%h w=%0d",
                     busy0, tt0, w0, snap_tt, snap_w);
        end
        sweep0(1, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC, 7'd32, 1'b1, "restart");
    endtask

    task automatic test_reset_midsweep();
        int cyc;
        mode0 = 3;
        exp0  = '1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 0;
        while (vec0 !== 6'd20 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (vec0 !== 6'd20) begin
            errors++;
            $display("FAIL midsweep_reach20: got vec=%0d expected 20", vec0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec0, tt0, w0, m0, v0, busy0} !== '0 || {tt2, w2, busy2} !== '0) begin
            errors++;
            $display("FAIL midsweep_reset: got vec=%h tt=%h w=%0d m=%b v=%b busy=%b tt2=%h expected all 0",
                     vec0, tt0, w0, m0, v0, busy0, tt2);
        end
        sb0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep0(1, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC, 7'd32, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_functions();
        test_settle2();
        test_hold();
        test_reset_midsweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
